// File: rtl/wvfm_pkg.sv
// Shared definitions for the waveform LUT loader.
// - LUT_AW / LUT_BYTES : geometry of the waveform LUT (byte addressed)
// - state_t            : loader FSM state, also exported on the debug port
package wvfm_pkg;

    localparam int LUT_AW    = 12;
    localparam int LUT_BYTES = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/wvfm_lut_loader_if.sv
// Host byte stream into the waveform LUT loader.
// - s_valid : host has a byte on s_data
// - s_data  : 4 packed 2-bit LUT entries, entry0 in [1:0]
// - s_ready : loader can take the byte this cycle
// Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
// are both 1. While s_valid=1 and s_ready=0 the host must hold s_data stable;
// s_ready never depends on s_valid.
// Modports: master = host side, slave = loader side.
interface wvfm_lut_loader_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/wvfm_byte_fifo.sv
// Small synchronous FIFO buffering host bytes ahead of LUT writes.
// - push/din   : write din when push (accepted when not full, or when full
//                and a pop happens in the same cycle)
// - pop/dout   : dout is the head entry, valid with zero latency when !empty
// - flush      : drop all contents; overrides push and pop in that cycle
// - full/empty : occupancy flags
module wvfm_byte_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only read when the pointers say non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/wvfm_lut_loader.sv
// Waveform LUT loader: buffers a host byte burst and writes it into the LUT
// SRAM through port A, only in cycles where the pixel pipeline is blanking.
// Ports:
// - clk, rst_n          : clock, asynchronous active-low reset
// - start, base_addr,
//   length, abort       : load control (start/abort are 1-cycle pulses)
// - host                : host byte stream (valid/ready, slave side)
// - blank               : pipeline is not reading LUT port A
// - lut_we/addr/din     : LUT write port (lut_busy mirrors lut_we)
// - busy, done, err     : load status (err sticky until the next start)
// - dbg_state           : current FSM state
module wvfm_lut_loader
    import wvfm_pkg::*;
#(
    parameter int AW         = LUT_AW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         length,
    input  logic                abort,
    wvfm_lut_loader_if.slave    host,
    input  logic                blank,
    output logic                lut_we,
    output logic [AW-1:0]       lut_addr,
    output logic [7:0]          lut_din,
    output logic                lut_busy,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              dbg_state
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remaining_q, remaining_d;     // bytes still to be written
    logic [AW:0]   accept_left_q, accept_left_d; // bytes still to be accepted
    logic          wr_q, wr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          err_q, err_d;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic          s_ready;

    logic          start_ok;
    logic          abort_ok;
    logic          last_wr;

    // Abort beats a simultaneous start; abort only matters while loading.
    assign start_ok = start & ~abort & (state_q == IDLE);
    assign abort_ok = abort & (state_q == LOAD);
    assign last_wr  = wr_q & (remaining_q == (AW+1)'(1));

    wvfm_byte_fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (host.s_data),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = (length == '0) ? FINISH : LOAD;
            LOAD:    if (abort_ok || last_wr) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state_q == LOAD);
        done       = (state_q == FINISH);
        // Stop accepting once length bytes have come in.
        s_ready    = (state_q == LOAD) & ~fifo_full & (accept_left_q != '0);
        fifo_push  = host.s_valid & s_ready;
        // A pop launches next cycle's write, so it needs blank sampled high;
        // an abort on this edge cancels it.
        fifo_pop   = (state_q == LOAD) & ~fifo_empty & blank & ~abort_ok;
        fifo_flush = abort_ok;
    end

    assign host.s_ready = s_ready;

    // ---------------- Address / counters / write register ----------------
    always_comb begin
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        accept_left_d = accept_left_q;
        err_d         = err_q;
        wr_d          = fifo_pop;
        wr_data_d     = fifo_pop ? fifo_dout : wr_data_q;

        if (start_ok) begin
            addr_d        = base_addr;
            remaining_d   = length;
            accept_left_d = length;
            err_d         = 1'b0;
        end else begin
            if (fifo_push) accept_left_d = accept_left_q - (AW+1)'(1);
            if (wr_q) begin
                addr_d      = addr_q + AW'(1);
                remaining_d = remaining_q - (AW+1)'(1);
                // Writing the top address with bytes still to go wraps to 0.
                if ((&addr_q) && (remaining_q > (AW+1)'(1))) err_d = 1'b1;
            end
            if (abort_ok) begin
                err_d         = 1'b1;
                accept_left_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            accept_left_q <= '0;
            wr_q          <= 1'b0;
            wr_data_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            accept_left_q <= accept_left_d;
            wr_q          <= wr_d;
            wr_data_q     <= wr_data_d;
            err_q         <= err_d;
        end
    end

    assign lut_we    = wr_q;
    assign lut_busy  = wr_q;
    assign lut_addr  = addr_q;
    assign lut_din   = wr_data_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wvfm_lut_loader.sv
// Bench for wvfm_lut_loader: random host bytes and blank patterns, with the
// expected LUT writes derived from base/length/abort point and checked by a
// monitor against an expected queue.
module tb_wvfm_lut_loader;
    import wvfm_pkg::*;

    localparam int AW     = 12;
    localparam int FDEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          blank = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          lut_we, lut_busy, busy, done, err;
    logic [AW-1:0] lut_addr;
    logic [7:0]    lut_din;
    state_t        dbg_state;

    wvfm_lut_loader_if host_if ();

    wvfm_lut_loader #(.AW(AW), .FIFO_DEPTH(FDEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .host      (host_if),
        .blank     (blank),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_din   (lut_din),
        .lut_busy  (lut_busy),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] exp_q[$];     // {addr, data} of each expected LUT write
    logic [7:0]  tx_q[$];      // bytes the host still has to deliver
    logic [7:0]  fixed_q[$];   // optional fixed payload for the next load
    int          blank_mode = 0; // 0 high, 1 3-high/3-low, 2 low, 3 random
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          cur_len = 0;
    bit          exp_err = 1'b0;
    bit          chk_we_before_done = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- blank driver ----------------
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (blank_mode)
                0: blank = 1'b1;
                1: begin blank = (ph < 3); ph = (ph + 1) % 6; end
                2: blank = 1'b0;
                default: blank = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- host byte driver ----------------
    initial begin
        bit fire;
        host_if.s_valid = 1'b0;
        host_if.s_data  = '0;
        forever begin
            @(negedge clk);
            fire = host_if.s_valid & host_if.s_ready & rst_n;
            @(posedge clk); #1;
            if (fire && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                acc_cnt++;
            end
            if (host_if.s_valid && !fire && tx_q.size() > 0) begin
                // hold the offered byte until it is taken
            end else if (tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                host_if.s_valid = 1'b1;
                host_if.s_data  = tx_q[0];
            end else begin
                host_if.s_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit          last_blank;
        bit          prev_we;
        logic [19:0] e;
        last_blank = 1'b0;
        prev_we    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_blank = 1'b0;
                prev_we    = 1'b0;
                continue;
            end
            check("lut_busy", lut_busy, lut_we);
            if (lut_we) begin
                check("we_after_blank", last_blank, 1);
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             lut_addr, lut_din);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", lut_addr, e[19:8]);
                    check("wr_data", lut_din, e[7:0]);
                end
            end
            if (busy && acc_cnt >= cur_len) check("no_ready_past_length", host_if.s_ready, 0);
            if (done) begin
                done_cnt++;
                check("done_err", err, exp_err);
                check("done_busy", busy, 0);
                check("done_no_we", lut_we, 0);
                check("done_writes_left", exp_q.size(), 0);
                if (chk_we_before_done) check("done_after_last_we", prev_we, 1);
            end
            prev_we    = lut_we;
            last_blank = blank;
        end
    end

    // ---------------- driver tasks ----------------
    // abort_at > 0: abort during the cycle carrying write number abort_at.
    task automatic run_load(input logic [AW-1:0] b, input int len, input int bmode,
                            input int abort_at);
        int         n_exp;
        int         d0;
        int         budget;
        int         t;
        logic [7:0] d;
        budget             = 4 * len + 200;
        n_exp              = (abort_at > 0) ? abort_at : len;
        exp_err            = (abort_at > 0) || (int'(b) + len > LUT_BYTES);
        chk_we_before_done = (len > 0);
        cur_len            = len;
        acc_cnt            = 0;
        wr_cnt             = 0;
        blank_mode         = bmode;
        for (int i = 0; i < len; i++) begin
            d = (i < fixed_q.size()) ? fixed_q[i] : 8'($urandom);
            tx_q.push_back(d);
            if (i < n_exp) exp_q.push_back({b + AW'(i), d});
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        base_addr = b;
        length    = (AW+1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_clear_on_start", err, 0);
        check("busy_after_start", busy, (len > 0));
        if (len == 0) begin
            @(negedge clk);
            check("len0_done_next_cycle", done, 1);
        end
        if (bmode == 2) begin
            repeat (40) @(negedge clk);
            #1;
            check("bp_accepted_depth", acc_cnt, (len < FDEPTH) ? len : FDEPTH);
            check("bp_ready_low", host_if.s_ready, 0);
            blank_mode = 0;
        end
        if (abort_at > 0) begin
            t = 0;
            while (wr_cnt < abort_at && t < budget) begin
                @(negedge clk); #1;
                t++;
            end
            check("abort_point_reached", wr_cnt, abort_at);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_seen", done_cnt - d0, 1);
        tx_q.delete();
        host_if.s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int t;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_lut_we", lut_we, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_lut_din", lut_din, 0);
        check("rst_lut_busy", lut_busy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_s_ready", host_if.s_ready, 0);
        check("rst_state", dbg_state, IDLE);

        // basic load with a fixed payload
        fixed_q = '{8'h1B, 8'h2C, 8'h3D, 8'h4E};
        run_load(12'h100, 4, 0, 0);
        fixed_q.delete();

        run_load(12'($urandom), 8, 1, 0);   // blank gating
        run_load(12'($urandom), 6, 2, 0);   // backpressure
        run_load(12'h123, 0, 0, 0);         // zero length
        run_load(12'hFFE, 4, 0, 0);         // wrap past the top
        run_load(12'hFFC, 4, 0, 0);         // ends exactly at the top
        run_load(12'($urandom), 6, 0, 2);   // abort after 2 writes
        run_load(12'($urandom), 5, 1, 0);   // restart clears err
        run_load(12'($urandom), 3, 0, 3);   // abort on the last write

        // start and abort together in IDLE: nothing starts
        d0 = done_cnt;
        @(posedge clk); #1;
        base_addr = 12'h040; length = 13'd4; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        check("start_abort_no_done", done_cnt - d0, 0);

        for (int k = 0; k < 8; k++) begin
            t = $urandom_range(0, 2);
            run_load(12'($urandom), $urandom_range(1, 24), (t == 2) ? 3 : t, 0);
        end
        run_load(12'h000, 4096, 3, 0);      // full LUT

        // asynchronous reset in the middle of a write cycle
        cur_len = 8; acc_cnt = 0; wr_cnt = 0; exp_err = 1'b0;
        chk_we_before_done = 1'b1; blank_mode = 0;
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(8'($urandom));
            exp_q.push_back({12'h200 + 12'(i), tx_q[i]});
        end
        @(posedge clk); #1;
        base_addr = 12'h200; length = 13'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (wr_cnt < 3 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("rst_mid_reached", wr_cnt, 3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_lut_we", lut_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_s_ready", host_if.s_ready, 0);
        exp_q.delete();
        tx_q.delete();
        host_if.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
